fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch and program-counter stage of the single-cycle MIPS core. It sits upstream of the control unit: it holds the current instruction, whose op and func fields feed the control unit.
- It consumes the control unit's pcsource (00 seq, 01 branch, 10 jr, 11 jump) and computes the next PC.
- It talks to instruction memory over a req/ack handshake, so the core stalls on slow memory.
- It halts on a misaligned jr target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pcsource  in  2  next-PC select from control unit: 00 pc+4, 01 branch, 10 jr, 11 j/jal
- ra  in  32  register-file rs read value; the jr target
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc
- imem_ack  in  1  memory response valid; imem_rdata is sampled in the same cycle
- imem_rdata  in  32  instruction word
- inst  out  32  held instruction; [31:26] is op, [5:0] is func, both to the control unit
- inst_valid  out  1  execute strobe; the datapath may write reg/mem only while high
- pc  out  32  current PC
- pc4  out  32  pc+4, for jal link writeback
- halted  out  1  sticky misalignment fault flag

Behaviour:
- Reset (asynchronous; takes effect immediately, mid-handshake included):
  - pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, halted=0, state=IDLE.
  - Any pending fetch is abandoned. A later ack is ignored because the FSM is no longer in FETCH.
- FSM states and transitions:
  - IDLE: imem_req=0. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc held stable. On a cycle with imem_ack=1: inst<=imem_rdata, then EXEC. Without ack it stays in FETCH indefinitely.
  - EXEC: inst_valid=1 and imem_req=0 for exactly one cycle. At the closing edge, pc<=next_pc, then FETCH. If next_pc[1:0]!=0, pc is not updated and the FSM goes to HALT instead.
  - HALT: halted=1, imem_req=0, inst_valid=0. Absorbing state; only rst exits it.
- Minimum throughput is one instruction per 2 cycles (ack in the first FETCH cycle). Fetch latency equals the ack delay.
- imem_ack outside FETCH is ignored. imem_rdata is don't-care when ack=0.
- pcsource and ra are sampled only at the EXEC edge; their values in other states are ignored.
- next_pc arithmetic (all 32-bit, wrap modulo 2^32, no overflow flag):
  - 00: pc+4
  - 01: pc+4 + ({{14{inst[15]}}, inst[15:0], 2'b00})
  - 10: ra
  - 11: {pc4[31:28], inst[25:0], 2'b00}
- Only the jr target can be misaligned, so it is the only source of HALT.
- pc=32'hFFFF_FFFC with pcsource 00 wraps to 0.
- Outputs pc4 and next_pc are combinational from pc/inst. All other outputs are registered or decoded from state.

Decomposition:
- Package fetch_pkg holds:
  - PCSRC_SEQ/BR/JR/J encodings (2'b00..2'b11), shared with the control unit
  - FSM state enum IDLE/FETCH/EXEC/HALT (2 bits)
  - INST_NOP=32'h0
- One sub-module, npc_calc: purely combinational. Inputs pc, inst, ra, pcsource; outputs next_pc, pc4, misalign.

Test Plan:
- Reset, ack tied high: cycle 1 IDLE; then imem_req=1 at addr 0; 2-cycle cadence; pc 0,4,8,C with pcsource=00.
- Ack delayed 3 cycles: imem_req and imem_addr stay stable for 4 cycles; inst_valid pulses exactly once after the ack.
- Branch at pc=0x10, inst[15:0]=16'hFFFE, pcsource=01 -> next pc=0x0C. With inst[15:0]=0x0003 -> pc=0x20.
- jal at pc=0x3000_0040, inst[25:0]=26'h0000100, pcsource=11 -> pc=0x3000_0400; pc4=0x3000_0044 during EXEC.
- jr with ra=0x0000_0102 -> halted=1, pc stays at the jr address, imem_req=0 forever; rst clears it back to RESET_PC.
- rst asserted in the middle of FETCH, with ack arriving after release during IDLE -> ack ignored, inst=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: next-PC select, fetch FSM states and the NOP word.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch, jr and jump targets plus misalignment flag.
module npc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] next_pc,
  output logic [31:0] pc4,
  output logic        misalign
);

  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic        unused_op;

  assign pc4     = pc + 32'd4;
  assign br_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], inst[25:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PCSRC_SEQ: next_pc = pc4;
      PCSRC_BR:  next_pc = pc4 + br_off;
      PCSRC_JR:  next_pc = ra;
      PCSRC_J:   next_pc = jmp_tgt;
      default:   next_pc = pc4;
    endcase
  end

  // Only a jr target can carry nonzero low bits; the others are built word-aligned.
  assign misalign  = (next_pc[1:0] != 2'b00);
  assign unused_op = ^inst[31:26];

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage: req/ack instruction fetch, one-cycle execute strobe, next-PC update, sticky halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        halted
);

  fetch_state_t state, state_n;
  logic [31:0]  next_pc;
  logic         misalign;
  logic         load_inst;
  logic         load_pc;

  npc_calc u_npc (
    .pc       (pc),
    .inst     (inst),
    .ra       (ra),
    .pcsource (pcsource),
    .next_pc  (next_pc),
    .pc4      (pc4),
    .misalign (misalign)
  );

  assign imem_addr = pc;

  // Next-state and register-load decode.
  always_comb begin
    state_n   = state;
    load_inst = 1'b0;
    load_pc   = 1'b0;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: begin
        if (imem_ack) begin
          load_inst = 1'b1;
          state_n   = EXEC;
        end
      end
      EXEC: begin
        if (misalign) begin
          state_n = HALT;
        end else begin
          load_pc = 1'b1;
          state_n = FETCH;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // State, PC, instruction and state-decoded outputs, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= INST_NOP;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      if (load_pc)   pc   <= next_pc;
      if (load_inst) inst <= imem_rdata;
      imem_req   <= (state_n == FETCH);
      inst_valid <= (state_n == EXEC);
      halted     <= (state_n == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner cases, random program vs PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc  = 32'h0;
  logic        mhalt = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcsource   (pcsource),
    .ra         (ra),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] ins;
    logic [1:0]  ps;
    logic [31:0] rav;
    int          dly;
    logic [31:0] exp_pc;
    logic        exp_halt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference next PC computed with plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [1:0] ps, input logic [31:0] r);
    int off;
    case (ps)
      2'd0: return p + 32'd4;
      2'd1: begin
        off = int'($signed(ins[15:0]));
        return p + 32'd4 + 32'(off * 4);
      end
      2'd2: return r;
      default: return ((p + 32'd4) & 32'hF000_0000) + (32'(ins[25:0]) * 32'd4);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    mpc = 32'h0;
    mhalt = 1'b0;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  // Runs one fetch/execute of ins starting at a negedge in FETCH; ack comes after dly cycles.
  task automatic run_instr(input logic [31:0] ins, input logic [1:0] ps,
                           input logic [31:0] rav, input int dly);
    logic [31:0] exp_pc;
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, mpc);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      pcsource = 2'($urandom);
      ra = $urandom;
      @(negedge clk);
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, mpc);
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_inst", inst, ins);
    chk("exec_pc4", pc4, mpc + 32'd4);
    chk("exec_req", 32'(imem_req), 32'd0);
    imem_ack = 1'($urandom);
    imem_rdata = $urandom;
    pcsource = ps;
    ra = rav;
    exp_pc = model_next(mpc, ins, ps, rav);
    @(negedge clk);
    imem_ack = 1'b0;
    pcsource = 2'($urandom);
    ra = $urandom;
    chk("hold_inst", inst, ins);
    chk("post_valid", 32'(inst_valid), 32'd0);
    if (exp_pc % 4 != 0) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc", pc, mpc);
      chk("halt_req", 32'(imem_req), 32'd0);
      mhalt = 1'b1;
    end else begin
      chk("next_pc", pc, exp_pc);
      chk("next_req", 32'(imem_req), 32'd1);
      chk("no_halt", 32'(halted), 32'd0);
      mpc = exp_pc;
    end
  endtask

  initial begin
    // ins, pcsource, ra, ack delay, expected pc, expected halted
    tbl[0]  = '{32'h0000_0000, 2'b00, 32'h0,         0, 32'h0000_0004, 1'b0};
    tbl[1]  = '{32'h2408_0001, 2'b00, 32'h0,         0, 32'h0000_0008, 1'b0};
    tbl[2]  = '{32'h2409_0002, 2'b00, 32'h0,         3, 32'h0000_000C, 1'b0};
    tbl[3]  = '{32'h0000_0020, 2'b00, 32'h0,         1, 32'h0000_0010, 1'b0};
    tbl[4]  = '{32'h1000_FFFE, 2'b01, 32'h0,         0, 32'h0000_000C, 1'b0};
    tbl[5]  = '{32'h0000_0000, 2'b00, 32'h0,         0, 32'h0000_0010, 1'b0};
    tbl[6]  = '{32'h1000_0003, 2'b01, 32'h0,         2, 32'h0000_0020, 1'b0};
    tbl[7]  = '{32'h0320_0008, 2'b10, 32'h3000_0040, 0, 32'h3000_0040, 1'b0};
    tbl[8]  = '{32'h0C00_0100, 2'b11, 32'h0,         0, 32'h3000_0400, 1'b0};
    tbl[9]  = '{32'h0320_0008, 2'b10, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1'b0};
    tbl[10] = '{32'h0000_0000, 2'b00, 32'h0,         0, 32'h0000_0000, 1'b0};
    tbl[11] = '{32'h0000_0000, 2'b00, 32'h0,         0, 32'h0000_0004, 1'b0};
    tbl[12] = '{32'h0320_0008, 2'b10, 32'h0000_0102, 0, 32'h0000_0004, 1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].ins, tbl[i].ps, tbl[i].rav, tbl[i].dly);
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_halt", 32'(halted), 32'(tbl[i].exp_halt));
    end

    // Halt is absorbing: acks ignored, no requests, pc frozen at the jr address.
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("halt_hold", 32'(halted), 32'd1);
      chk("halt_hold_req", 32'(imem_req), 32'd0);
      chk("halt_hold_valid", 32'(inst_valid), 32'd0);
      chk("halt_hold_pc", pc, 32'h0000_0004);
    end
    do_reset();

    // Reset mid-fetch; an ack during the following IDLE cycle must not load inst.
    run_instr(32'h2408_0001, 2'b00, 32'h0, 0);
    run_instr(32'h2409_0002, 2'b00, 32'h0, 0);
    imem_ack = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_inst", inst, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_inst", inst, 32'h0);
    chk("restart_valid", 32'(inst_valid), 32'd0);
    mpc = 32'h0;
    mhalt = 1'b0;
    run_instr(32'h2408_0005, 2'b00, 32'h0, 1);

    // Random program against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  ps;
      logic [31:0] rv;
      if (mhalt) do_reset();
      ps = 2'($urandom_range(0, 3));
      rv = $urandom & 32'hFFFF_FFFC;
      if (ps == 2'b10 && $urandom_range(0, 7) == 0) rv = rv | 32'($urandom_range(1, 3));
      run_instr($urandom, ps, rv, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
